// File: rtl/spectrum_bar_renderer_if.sv
// Magnitude write port from the FFT/magnitude stage into the renderer's shadow bank.
interface spectrum_bar_renderer_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              mag_wr_en;
  logic [ADDR_W-1:0] mag_wr_addr;
  logic [9:0]        mag_wr_data;

  modport master (
    output mag_wr_en,
    output mag_wr_addr,
    output mag_wr_data
  );

  modport slave (
    input mag_wr_en,
    input mag_wr_addr,
    input mag_wr_data
  );
endinterface

// File: rtl/spectrum_bar_renderer.sv
// Spectrum bar pixel stage: shadow/display magnitude banks with a vblank commit,
// falling peak-hold markers, and a two-stage render pipeline with aligned syncs.
module spectrum_bar_renderer #(
  parameter int unsigned NUM_BARS   = 32,
  parameter int unsigned BAR_WIDTH  = 20,
  parameter int unsigned GAP        = 2,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned PEAK_DECAY = 2
) (
  input  logic                          sclk,
  input  logic                          rst_n,
  input  logic [9:0]                    x_pix,
  input  logic [9:0]                    y_pix,
  input  logic                          video_on,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  spectrum_bar_renderer_if.slave        mag,
  output logic [7:0]                    rgb,
  output logic                          video_on_out,
  output logic                          hsync_out,
  output logic                          vsync_out,
  output logic                          frame_commit
);

  localparam int unsigned AW       = $clog2(NUM_BARS);
  localparam logic [9:0]  MAG_MAX  = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  BAR_W10  = 10'(BAR_WIDTH);
  localparam logic [9:0]  GAP_COL  = 10'(BAR_WIDTH - GAP);
  localparam logic [9:0]  H_ACT10  = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT10  = 10'(V_ACTIVE);
  localparam logic [9:0]  NB10     = 10'(NUM_BARS);
  localparam logic [9:0]  DECAY10  = 10'(PEAK_DECAY);
  localparam logic [9:0]  GREEN_LIM  = 10'd240;
  localparam logic [9:0]  YELLOW_LIM = 10'd400;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMMIT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          vs_prev_q;
  logic          commit_en;

  logic [9:0] sh_q [NUM_BARS];
  logic [9:0] dm_q [NUM_BARS];
  logic [9:0] pk_q [NUM_BARS];

  logic [9:0] wr_val;
  logic [9:0] sh_cur, pk_cur, pk_dec, pk_new;

  // ---------------- commit FSM ----------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    commit_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (vs_prev_q && !vsync_in) begin
          state_d = S_COMMIT;
          idx_d   = '0;
        end
      end
      S_COMMIT: begin
        commit_en = 1'b1;
        idx_d     = idx_q + AW'(1);
        if (idx_q == AW'(NUM_BARS - 1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      vs_prev_q    <= 1'b1;
      frame_commit <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      vs_prev_q    <= vsync_in;
      frame_commit <= (state_q == S_DONE);
    end
  end

  // ---------------- magnitude banks ----------------
  always_comb begin
    wr_val = (mag.mag_wr_data > MAG_MAX) ? MAG_MAX : mag.mag_wr_data;
    sh_cur = sh_q[idx_q];
    pk_cur = pk_q[idx_q];
    pk_dec = (pk_cur > DECAY10) ? (pk_cur - DECAY10) : '0;
    pk_new = (sh_cur > pk_dec) ? sh_cur : pk_dec;
  end

  // The copy samples sh before this cycle's write lands, so a colliding write
  // is deferred to the following frame's commit.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < NUM_BARS; b++) begin
        sh_q[b] <= '0;
        dm_q[b] <= '0;
        pk_q[b] <= '0;
      end
    end else begin
      if (commit_en) begin
        dm_q[idx_q] <= sh_cur;
        pk_q[idx_q] <= pk_new;
      end
      if (mag.mag_wr_en) sh_q[mag.mag_wr_addr] <= wr_val;
    end
  end

  // ---------------- render stage 1 ----------------
  logic [9:0]    bar_full, col_c, h_c;
  logic [AW-1:0] bar_idx;
  logic          blank_c;

  always_comb begin
    bar_full = x_pix / BAR_W10;
    col_c    = x_pix % BAR_W10;
    h_c      = MAG_MAX - y_pix;
    bar_idx  = bar_full[AW-1:0];
    blank_c  = !video_on || (x_pix >= H_ACT10) || (y_pix >= V_ACT10) ||
               (bar_full >= NB10);
  end

  logic       blank_q;
  logic [9:0] col_q, h_q, dmv_q, pkv_q;
  logic       vo1_q, hs1_q, vs1_q;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= 1'b1;
      col_q   <= '0;
      h_q     <= '0;
      dmv_q   <= '0;
      pkv_q   <= '0;
      vo1_q   <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
    end else begin
      blank_q <= blank_c;
      col_q   <= col_c;
      h_q     <= h_c;
      dmv_q   <= dm_q[bar_idx];
      pkv_q   <= pk_q[bar_idx];
      vo1_q   <= video_on;
      hs1_q   <= hsync_in;
      vs1_q   <= vsync_in;
    end
  end

  // ---------------- render stage 2 ----------------
  logic [7:0] pix_c;

  always_comb begin
    pix_c = 8'h00;
    if (blank_q || (col_q >= GAP_COL)) begin
      pix_c = 8'h00;
    end else if ((pkv_q != '0) && (h_q == pkv_q)) begin
      pix_c = 8'hFF;
    end else if (h_q < dmv_q) begin
      if (h_q < GREEN_LIM)       pix_c = 8'h1C;
      else if (h_q < YELLOW_LIM) pix_c = 8'hFC;
      else                       pix_c = 8'hE0;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      rgb          <= 8'h00;
      video_on_out <= 1'b0;
      hsync_out    <= 1'b1;
      vsync_out    <= 1'b1;
    end else begin
      rgb          <= pix_c;
      video_on_out <= vo1_q;
      hsync_out    <= hs1_q;
      vsync_out    <= vs1_q;
    end
  end

endmodule

// File: tb/tb_spectrum_bar_renderer.sv
// Scoreboard bench for spectrum_bar_renderer: per-cycle expectations from a frame-level model.
module tb_spectrum_bar_renderer;
  localparam int NB  = 32;
  localparam int BW  = 20;
  localparam int GP  = 2;
  localparam int HA  = 640;
  localparam int VA  = 480;
  localparam int DEC = 2;

  logic       sclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x_pix = '0, y_pix = '0;
  logic       video_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic [7:0] rgb;
  logic       video_on_out, hsync_out, vsync_out, frame_commit;

  spectrum_bar_renderer_if #(.ADDR_W(5)) mag_if ();

  spectrum_bar_renderer #(
    .NUM_BARS(NB), .BAR_WIDTH(BW), .GAP(GP),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .PEAK_DECAY(DEC)
  ) dut (
    .sclk(sclk), .rst_n(rst_n), .x_pix(x_pix), .y_pix(y_pix),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .mag(mag_if), .rgb(rgb), .video_on_out(video_on_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .frame_commit(frame_commit)
  );

  always #5 sclk = ~sclk;

  int unsigned cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  rgb;
    logic        vo, hs, vs, fc;
  } exp_t;
  exp_t q[$];

  // Behavioural model: bank contents and the cycle of the last accepted vsync edge.
  int m_sh[NB], m_dm[NB], m_pk[NB];
  int t_edge = -1000;
  bit prev_vs = 1'b1;
  bit stim_done = 1'b0;

  function automatic logic [7:0] ref_pix(int x, int y, bit vo);
    int b, h;
    if (!vo || x >= HA || y >= VA) return 8'h00;
    if ((x % BW) >= BW - GP) return 8'h00;
    b = x / BW;
    h = VA - 1 - y;
    if (m_pk[b] != 0 && h == m_pk[b]) return 8'hFF;
    if (h < m_dm[b]) begin
      if (h < 240) return 8'h1C;
      if (h < 400) return 8'hFC;
      return 8'hE0;
    end
    return 8'h00;
  endfunction

  task automatic step(input int x, input int y, input bit vo, input bit hs, input bit vs,
                      input bit we = 1'b0, input int wa = 0, input int wd = 0);
    int   c, k, dk;
    exp_t e;
    c = int'(cyc);
    x_pix = 10'(x); y_pix = 10'(y);
    video_on = vo; hsync_in = hs; vsync_in = vs;
    mag_if.mag_wr_en = we; mag_if.mag_wr_addr = 5'(wa); mag_if.mag_wr_data = 10'(wd);
    e.cyc = cyc + 2; e.rgb = ref_pix(x, y, vo);
    e.vo = vo; e.hs = hs; e.vs = vs; e.fc = (c == t_edge + NB);
    q.push_back(e);
    if (c >= t_edge + 1 && c <= t_edge + NB) begin
      k  = c - t_edge - 1;
      dk = m_pk[k] - DEC;
      if (dk < 0) dk = 0;
      m_dm[k] = m_sh[k];
      m_pk[k] = (m_sh[k] > dk) ? m_sh[k] : dk;
    end
    if (prev_vs && !vs && c > t_edge + NB + 1) t_edge = c;
    prev_vs = vs;
    if (we) m_sh[wa] = (wd > VA - 1) ? VA - 1 : wd;
    @(posedge sclk); #1;
  endtask

  task automatic rstep(input bit vs, input bit we = 1'b0);
    int x, y;
    bit vo;
    x  = $urandom_range(0, 799);
    y  = $urandom_range(0, 524);
    vo = (x < HA && y < VA) ^ ($urandom_range(0, 7) == 0);
    step(x, y, vo, $urandom_range(0, 5) != 0, vs, we,
         $urandom_range(0, NB - 1), $urandom_range(0, 1023));
  endtask

  task automatic vedge();
    for (int i = 0; i < 2; i++)  rstep(1'b1);
    for (int i = 0; i < 40; i++) rstep(1'b0);
    for (int i = 0; i < 2; i++)  rstep(1'b1);
  endtask

  task automatic push_reset_exp(input int unsigned c);
    exp_t e;
    e.cyc = c; e.rgb = 8'h00; e.vo = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.fc = 1'b0;
    q.push_back(e);
  endtask

  task automatic apply_reset(input int n);
    q.delete();
    rst_n = 1'b0;
    foreach (m_sh[i]) begin m_sh[i] = 0; m_dm[i] = 0; m_pk[i] = 0; end
    t_edge = -1000; prev_vs = 1'b1;
    for (int i = 0; i < n; i++) begin
      x_pix = 10'($urandom_range(0, 639)); y_pix = 10'($urandom_range(0, 479));
      video_on = 1'b1; hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      mag_if.mag_wr_en = 1'b1; mag_if.mag_wr_addr = 5'($urandom);
      mag_if.mag_wr_data = 10'($urandom);
      push_reset_exp(cyc);
      @(posedge sclk); #1;
    end
    mag_if.mag_wr_en = 1'b0;
    rst_n = 1'b1;
    push_reset_exp(cyc);
    push_reset_exp(cyc + 1);
  endtask

  // ---------------- monitor ----------------
  int   total = 0, bad = 0, drain = 0;
  exp_t m;

  always @(negedge sclk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      m = q.pop_front();
      total++; bad++;
      $display("FAIL stale_expect cyc=%0d got=none want_cyc=%0d", cyc, m.cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      m = q.pop_front();
      total++;
      if (rgb !== m.rgb || video_on_out !== m.vo || hsync_out !== m.hs ||
          vsync_out !== m.vs || frame_commit !== m.fc) begin
        bad++;
        $display("FAIL pixel cyc=%0d got rgb=%02h vo=%b hs=%b vs=%b fc=%b want rgb=%02h vo=%b hs=%b vs=%b fc=%b",
                 cyc, rgb, video_on_out, hsync_out, vsync_out, frame_commit,
                 m.rgb, m.vo, m.hs, m.vs, m.fc);
      end
    end
    if (stim_done) begin
      drain++;
      if (q.size() == 0 || drain > 8) begin
        if (q.size() != 0) begin
          bad++;
          $display("FAIL drain got=%0d_pending want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench did not finish");
  end

  // ---------------- stimulus ----------------
  int ys1[6] = '{378, 379, 380, 381, 430, 479};
  int ys2[9] = '{0, 1, 79, 80, 81, 239, 240, 241, 479};
  int ys3[6] = '{428, 429, 430, 431, 470, 479};
  int xs0[5] = '{0, 9, 17, 18, 19};

  initial begin
    mag_if.mag_wr_en = 1'b0; mag_if.mag_wr_addr = '0; mag_if.mag_wr_data = '0;
    @(posedge sclk); #1;
    apply_reset(4);

    // empty banks: a stretch of random pixels must stay black
    for (int i = 0; i < 300; i++) rstep(1'b1);

    // single bar 3 = 100
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 3, 100);
    vedge();
    for (int x = 56; x <= 81; x++)
      foreach (ys1[j]) step(x, ys1[j], 1'b1, 1'b1, 1'b1);
    step(40, 379, 1'b1, 1'b1, 1'b1);

    // peak decay on bar 0
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 300);
    vedge();
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
    for (int f = 0; f < 3; f++) begin
      foreach (xs0[j])
        for (int y = VA - 1 - 305; y < VA; y++) step(xs0[j], y, 1'b1, 1'b1, 1'b1);
      vedge();
    end

    // saturation and colour bands on bar 31
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 31, 900);
    vedge();
    for (int x = 618; x <= 639; x++)
      foreach (ys2[j]) step(x, ys2[j], 1'b1, 1'b1, 1'b1);
    for (int x = 640; x < 650; x++) step(x, 0, 1'b1, 1'b1, 1'b1);
    step(620, 200, 1'b1, 1'b1, 1'b1);
    step(620, 500, 1'b1, 1'b1, 1'b1);

    // write/copy collision on bar 5
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 5, 10);
    vedge();
    step(0, 0, 1'b0, 1'b1, 1'b1);
    step(0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(0, 0, 1'b0, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 5, 50);
    for (int i = 0; i < 40; i++) step(0, 0, 1'b0, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b1, 1'b1);
    for (int f = 0; f < 2; f++) begin
      for (int x = 100; x < 120; x++)
        foreach (ys3[j]) step(x, ys3[j], 1'b1, 1'b1, 1'b1);
      vedge();
    end

    // random traffic: writes, pixels, sync toggles including edges while busy
    begin
      bit vs_r;
      vs_r = 1'b1;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 39) == 0) vs_r = ~vs_r;
        rstep(vs_r, $urandom_range(0, 3) == 0);
      end
    end

    // reset while a commit is in progress
    for (int i = 0; i < 2; i++)  rstep(1'b1);
    for (int i = 0; i < 12; i++) rstep(1'b0);
    apply_reset(3);
    for (int i = 0; i < 300; i++) rstep(1'b1);
    vedge();
    for (int i = 0; i < 300; i++) rstep(1'b1);
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 7, 123);
    vedge();
    for (int x = 140; x < 160; x++)
      foreach (ys1[j]) step(x, ys1[j] - 20, 1'b1, 1'b1, 1'b1);

    stim_done = 1'b1;
  end

endmodule
